// File: rtl/marie_pkg.sv
// Shared MARIE definitions: opcodes, sequencer states and the
// Skipcond evaluation helper used by fetch_decode.
package marie_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        JNS      = 4'h0,
        LOAD     = 4'h1,
        STORE    = 4'h2,
        ADD      = 4'h3,
        SUBT     = 4'h4,
        INPUT    = 4'h5,
        OUTPUT   = 4'h6,
        HALT     = 4'h7,
        SKIPCOND = 4'h8,
        JUMP     = 4'h9,
        CLEAR    = 4'hA,
        ADDI     = 4'hB,
        JUMPI    = 4'hC,
        LOADI    = 4'hD,
        STOREI   = 4'hE
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        LATCH,
        DECODE,
        EXEC,
        HALTED
    } fd_state_t;

    // cond 00: AC<0, 01: AC==0, 10: AC>0, 11: never (AC is signed)
    function automatic logic skip_taken(
        input logic [1:0]        cond,
        input logic [DATA_W-1:0] ac
    );
        logic signed [DATA_W-1:0] s;
        s = signed'(ac);
        unique case (cond)
            2'b00:   skip_taken = (s < 0);
            2'b01:   skip_taken = (s == 0);
            2'b10:   skip_taken = (s > 0);
            default: skip_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fetch_decode.sv
// MARIE instruction sequencer: fetches, decodes, resolves Jump,
// Skipcond and Halt locally, dispatches everything else.
module fetch_decode #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] AC,
    output logic              op_valid,
    output logic [3:0]        opcode,
    output logic [ADDR_W-1:0] X,
    input  logic              op_done,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic              halted
);
    import marie_pkg::*;

    fd_state_t state;
    fd_state_t state_next;
    logic [3:0] ir_op;
    logic [1:0] ir_cond;

    assign ir_op    = IR[DATA_W-1 -: 4];
    assign ir_cond  = IR[ADDR_W-1 -: 2];
    assign opcode   = ir_op;
    assign X        = IR[ADDR_W-1:0];
    assign mem_addr = PC;

    // Next-state logic; the FETCH after reset waits for the mem_rd flop
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:  state_next = mem_rd ? LATCH : FETCH;
            LATCH:  state_next = DECODE;
            DECODE: begin
                case (ir_op)
                    JUMP:     state_next = FETCH;
                    SKIPCOND: state_next = FETCH;
                    HALT:     state_next = HALTED;
                    default:  state_next = EXEC;
                endcase
            end
            EXEC:   state_next = op_done ? FETCH : EXEC;
            HALTED: state_next = HALTED;
            default: state_next = FETCH;
        endcase
    end

    // State register with registered strobes derived from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            mem_rd   <= 1'b0;
            op_valid <= 1'b0;
        end else begin
            state    <= state_next;
            mem_rd   <= (state_next == FETCH);
            op_valid <= (state_next == EXEC);
        end
    end

    // Datapath: PC, IR and the sticky halt flag
    always_ff @(posedge clk) begin
        if (rst) begin
            PC     <= RESET_PC;
            IR     <= '0;
            halted <= 1'b0;
        end else begin
            unique case (state)
                LATCH: begin
                    IR <= mem_rdata;
                    PC <= PC + 1'b1;
                end
                DECODE: begin
                    case (ir_op)
                        JUMP: PC <= IR[ADDR_W-1:0];
                        SKIPCOND: begin
                            if (skip_taken(ir_cond, AC))
                                PC <= PC + 1'b1;
                        end
                        HALT: halted <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
